// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM encoding, NOP word and the sequential PC step.
package riscv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } if_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds one fetched instruction and its PC; flush wins over load.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic            o_valid
);

  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding imem requests, IF/ID holding register,
// sequential and redirect PC updates with stale-response draining.
module if_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_write,
  output logic [XLEN-1:0] next_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_misaligned
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INC);

  if_state_e       r_state;
  if_state_e       w_state_nxt;
  logic [XLEN-1:0] r_req_addr;
  logic            w_accept;
  logic            w_load;
  logic            w_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_addr <= '0;
    end else if (w_accept) begin
      r_req_addr <= pc_in;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    imem_req_valid = 1'b0;
    imem_addr      = '0;
    pc_write       = 1'b0;
    next_pc        = '0;
    w_accept       = 1'b0;
    w_load         = 1'b0;
    w_flush        = 1'b0;

    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        imem_req_valid = 1'b1;
        imem_addr      = pc_in;
        w_accept       = imem_req_ready;
        if (imem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          w_load      = 1'b1;
          pc_write    = 1'b1;
          next_pc     = r_req_addr + PC_STEP;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (id_ready) begin
          w_flush     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_resp_valid) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A response landing in the redirect cycle has no follow-up in flight, so only
    // a still-pending response sends the FSM to DRAIN.
    if (redirect_valid) begin
      pc_write = 1'b1;
      next_pc  = redirect_pc;
      w_load   = 1'b0;
      w_flush  = 1'b1;
      case (r_state)
        S_REQ:   w_state_nxt = imem_req_ready  ? S_DRAIN : S_REQ;
        S_WAIT:  w_state_nxt = imem_resp_valid ? S_REQ   : S_DRAIN;
        S_DRAIN: w_state_nxt = imem_resp_valid ? S_REQ   : S_DRAIN;
        default: w_state_nxt = S_REQ;
      endcase
    end

    if (reset) begin
      pc_write = 1'b0;
      next_pc  = '0;
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_instr (imem_resp_data),
    .i_pc    (r_req_addr),
    .o_instr (id_instr),
    .o_pc    (id_pc),
    .o_valid (id_valid)
  );

  assign id_misaligned = |id_pc[1:0];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a PC-register model, a latency-programmable
// instruction memory and a scoreboard of expected IF/ID contents.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_write;
  logic [31:0] next_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_misaligned;

  if_stage #(
    .XLEN      (32),
    .NOP_INSTR (NOP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_in           (pc_in),
    .pc_write        (pc_write),
    .next_pc         (next_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_misaligned   (id_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic        s_reqv, s_acc, s_pcw, s_idv, s_rise, prev_valid;
  logic [31:0] s_addr, s_npc;
  logic        mem_busy;
  logic [31:0] mem_addr;
  int unsigned mem_cnt, mem_lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[11:0], 20'h00093};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_env();
    pc_in           = '0;
    mem_busy        = 1'b0;
    mem_cnt         = 0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    prev_valid      = 1'b0;
    sb.delete();
  endtask

  // One clock: sample at negedge, then update PC register and memory just after posedge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    s_reqv     = imem_req_valid;
    s_addr     = imem_addr;
    s_acc      = imem_req_valid && imem_req_ready;
    s_pcw      = pc_write;
    s_npc      = next_pc;
    s_idv      = id_valid;
    s_rise     = id_valid && !prev_valid;
    prev_valid = id_valid;
    if (s_rise) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("id_instr", id_instr, e.instr);
        chk("id_pc", id_pc, e.pc);
        chk("id_misaligned", 32'(id_misaligned), 32'(|e.pc[1:0]));
      end
    end
    if (s_acc) sb.push_back('{mem_word(s_addr), s_addr});
    if (redirect_valid) sb.delete();
    @(posedge clk);
    #1;
    if (s_pcw) pc_in = s_npc;
    imem_resp_valid = 1'b0;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_addr);
        mem_busy        = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    if (s_acc) begin
      if (mem_lat == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(s_addr);
      end else begin
        mem_busy = 1'b1;
        mem_addr = s_addr;
        mem_cnt  = mem_lat;
      end
    end
    if (reset) clear_env();
  endtask

  task automatic wait_accept(input int unsigned budget, input string tag);
    int unsigned n;
    n = 0;
    do begin cyc(); n++; end while (!s_acc && n < budget);
    chk(tag, 32'(s_acc), 32'd1);
  endtask

  task automatic wait_hold(input int unsigned budget, input string tag);
    int unsigned n;
    n = 0;
    do begin cyc(); n++; end while (!s_rise && n < budget);
    chk(tag, 32'(s_rise), 32'd1);
  endtask

  task automatic redirect_cyc(input logic [31:0] target, input string tag);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cyc();
    redirect_valid = 1'b0;
    chk({tag, "_pcw"}, 32'(s_pcw), 32'd1);
    chk({tag, "_npc"}, s_npc, target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned pcw_cnt, b2b;
    logic        last_pcw;

    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    mem_lat = 0;
    clear_env();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_write", 32'(pc_write), 32'd0);
    chk("rst_next_pc", next_pc, 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, NOP);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_misaligned", 32'(id_misaligned), 32'd0);
    reset = 1'b0;

    // Sequential fetch from 0 with zero-wait memory
    cyc();
    chk("idle_req_valid", 32'(s_reqv), 32'd0);
    cyc();
    chk("req0_valid", 32'(s_reqv), 32'd1);
    chk("req0_addr", s_addr, 32'd0);
    cyc();
    chk("seq_pcw", 32'(s_pcw), 32'd1);
    chk("seq_npc", s_npc, 32'd4);
    cyc();
    chk("hold0_rise", 32'(s_rise), 32'd1);
    id_ready = 1'b0;
    cyc();
    chk("req1_addr", s_addr, 32'd4);
    cyc();
    chk("seq1_npc", s_npc, 32'd8);

    // Backpressure in HOLD
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp_id_valid", 32'(s_idv), 32'd1);
      chk("bp_id_instr", id_instr, mem_word(32'd4));
      chk("bp_id_pc", id_pc, 32'd4);
      chk("bp_req_valid", 32'(s_reqv), 32'd0);
      chk("bp_pc_write", 32'(s_pcw), 32'd0);
    end
    id_ready = 1'b1;
    cyc();
    cyc();
    chk("req2_addr", s_addr, 32'd8);

    // Steady-state throughput: one pc_write per three cycles
    pcw_cnt = 0;
    b2b = 0;
    last_pcw = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      if (s_pcw) pcw_cnt++;
      if (s_pcw && last_pcw) b2b++;
      last_pcw = s_pcw;
    end
    chk("throughput", pcw_cnt, 32'd3);
    chk("pcw_back2back", b2b, 32'd0);
    wait_hold(8, "to_hold_a");

    // Redirect while waiting, stale response arrives two cycles later
    mem_lat = 1;
    wait_accept(8, "to_accept_a");
    redirect_cyc(32'h100, "rd_wait");
    cyc();
    chk("rd_wait_id_valid", 32'(s_idv), 32'd0);
    wait_accept(8, "rd_wait_accept");
    chk("rd_wait_addr", s_addr, 32'h100);
    wait_hold(8, "rd_wait_hold");

    // Redirect coincident with the response
    mem_lat = 0;
    wait_accept(8, "to_accept_b");
    redirect_cyc(32'h200, "rd_resp");
    wait_accept(8, "rd_resp_accept");
    chk("rd_resp_addr", s_addr, 32'h200);
    chk("rd_resp_id_valid", 32'(s_idv), 32'd0);
    wait_hold(8, "rd_resp_hold");

    // Memory stall
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_req_valid", 32'(s_reqv), 32'd1);
      chk("stall_addr", s_addr, 32'h204);
      chk("stall_acc", 32'(s_acc), 32'd0);
    end
    imem_req_ready = 1'b1;
    wait_accept(2, "stall_accept");
    chk("stall_acc_addr", s_addr, 32'h204);
    wait_hold(8, "stall_hold");
    chk("stall_single", 32'(sb.size()), 32'd0);

    // Redirect in HOLD to a misaligned target
    id_ready = 1'b0;
    wait_hold(8, "to_hold_b");
    redirect_cyc(32'h302, "rd_hold");
    id_ready = 1'b1;
    cyc();
    chk("rd_hold_id_valid", 32'(s_idv), 32'd0);
    chk("rd_hold_addr", s_addr, 32'h302);
    wait_hold(8, "misaligned_hold");

    // Back-to-back redirects: WAIT then DRAIN
    mem_lat = 2;
    wait_accept(8, "to_accept_c");
    redirect_cyc(32'h400, "rd_b2b1");
    redirect_cyc(32'h500, "rd_b2b2");
    chk("rd_b2b_drain", 32'(s_reqv), 32'd0);
    wait_accept(8, "rd_b2b_accept");
    chk("rd_b2b_addr", s_addr, 32'h500);
    wait_hold(8, "rd_b2b_hold");

    // Asynchronous reset between edges while a response is outstanding
    wait_accept(8, "to_accept_d");
    #2;
    reset = 1'b1;
    #1;
    chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("arst_pc_write", 32'(pc_write), 32'd0);
    chk("arst_id_valid", 32'(id_valid), 32'd0);
    chk("arst_id_instr", id_instr, NOP);
    chk("arst_id_pc", id_pc, 32'd0);
    clear_env();
    mem_lat = 0;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk("arst_idle", 32'(s_reqv), 32'd0);
    wait_accept(4, "arst_accept");
    chk("arst_addr", s_addr, 32'd0);
    wait_hold(8, "arst_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
